// File: rtl/hdmi_pll_pkg.sv
// hdmi_pll_pkg: shared state encoding and edge-count constants for the HDMI PLL supervisor
package hdmi_pll_pkg;
   typedef enum logic [2:0] {PLLRST, WAIT_LOCK, SETTLE, MEASURE, RUN, FAULT} state_t;
   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/cdc_sync2.sv
// cdc_sync2: two-flop synchronizer for a single asynchronous level
module cdc_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk) begin
      if (reset) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
   end
endmodule

// File: rtl/hdmi_pll_supervisor.sv
// hdmi_pll_supervisor: sequences rPLL reset, qualifies lock and pixel-clock rate, gates the HDMI pipeline
module hdmi_pll_supervisor
   import hdmi_pll_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 270,
   parameter int LOCK_TIMEOUT = 270000,
   parameter int SETTLE_CYCLES = 2700,
   parameter int WINDOW = 27000,
   parameter int EDGE_MIN = 140,
   parameter int EDGE_MAX = 150,
   parameter int MAX_RETRIES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_lock,
   input  logic pclk_tick,
   output logic pll_reset,
   output logic hdmi_reset,
   output logic ready,
   output logic fault,
   output logic [CNT_W-1:0] freq_count,
   output logic [1:0] retry_cnt
);
   state_t state, nxt;
   logic lock_s, tick_s, tick_d, tick_edge, win_end, in_range, fail;
   logic [31:0] tmr, lock_tmr;
   logic [CNT_W-1:0] edge_cnt, cnt_now;

   cdc_sync2 u_lock (.clk(clk), .reset(reset), .d(pll_lock), .q(lock_s));
   cdc_sync2 u_tick (.clk(clk), .reset(reset), .d(pclk_tick), .q(tick_s));

   always_comb begin
      tick_edge = tick_s ^ tick_d;
      cnt_now = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + CNT_W'(tick_edge);
      win_end = (state == MEASURE || state == RUN) && tmr == WINDOW - 1;
      in_range = int'(cnt_now) >= EDGE_MIN && int'(cnt_now) <= EDGE_MAX;
      nxt = state;
      fail = 1'b0;
      case (state)
         PLLRST:    if (tmr == PLL_RST_CYCLES - 1) nxt = WAIT_LOCK;
         WAIT_LOCK: if (lock_s) nxt = SETTLE; else fail = lock_tmr >= LOCK_TIMEOUT - 1;
         SETTLE:    if (!lock_s) nxt = WAIT_LOCK; else if (tmr == SETTLE_CYCLES - 1) nxt = MEASURE;
         MEASURE:   if (!lock_s || (win_end && !in_range)) fail = 1'b1; else if (win_end) nxt = RUN;
         RUN:       fail = !lock_s || (win_end && !in_range);
         default:   nxt = FAULT;
      endcase
      if (fail) nxt = (retry_cnt == 2'(MAX_RETRIES - 1)) ? FAULT : PLLRST;
   end

   // lock_tmr spans WAIT_LOCK and SETTLE so lock glitches cannot extend the timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= PLLRST;
         tmr <= '0;
         lock_tmr <= '0;
         edge_cnt <= '0;
         tick_d <= 1'b0;
         freq_count <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         hdmi_reset <= 1'b1;
         ready <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= nxt;
         tick_d <= tick_s;
         tmr <= (nxt != state || win_end) ? '0 : tmr + 32'd1;
         lock_tmr <= (state == PLLRST) ? '0 : (state == WAIT_LOCK || state == SETTLE) ? lock_tmr + 32'd1 : lock_tmr;
         edge_cnt <= (nxt != state || win_end) ? '0 : cnt_now;
         if (win_end) freq_count <= cnt_now;
         if (fail) retry_cnt <= retry_cnt + 2'd1;
         else if (nxt == RUN && state != RUN) retry_cnt <= '0;
         pll_reset <= nxt == PLLRST;
         hdmi_reset <= nxt != RUN;
         ready <= nxt == RUN;
         fault <= nxt == FAULT;
      end
   end
endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// tb_hdmi_pll_supervisor: randomized scenario bench; expectations come from edge-time arithmetic on the driven waveforms
module tb_hdmi_pll_supervisor;
   localparam int EMIN = 8, EMAX = 12, SAT = 1023, HN = 32768;
   logic clk = 0, reset = 1, pll_lock = 0, pclk_tick = 0;
   logic pll_reset, hdmi_reset, ready, fault, pll_reset2, hdmi_reset2, ready2, fault2;
   logic [9:0] freq_count, freq_count2;
   logic [1:0] retry_cnt, retry_cnt2;
   int cyc = 0, tick_per = 0, tests = 0, fails = 0, rst_edge = 0;
   bit hist [0:HN-1];

   hdmi_pll_supervisor #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(16), .WINDOW(64),
      .EDGE_MIN(EMIN), .EDGE_MAX(EMAX), .MAX_RETRIES(3)) dut (
      .clk(clk), .reset(reset), .pll_lock(pll_lock), .pclk_tick(pclk_tick), .pll_reset(pll_reset),
      .hdmi_reset(hdmi_reset), .ready(ready), .fault(fault), .freq_count(freq_count), .retry_cnt(retry_cnt));

   hdmi_pll_supervisor #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(16), .WINDOW(2000),
      .EDGE_MIN(EMIN), .EDGE_MAX(EMAX), .MAX_RETRIES(3)) dut2 (
      .clk(clk), .reset(reset), .pll_lock(pll_lock), .pclk_tick(pclk_tick), .pll_reset(pll_reset2),
      .hdmi_reset(hdmi_reset2), .ready(ready2), .fault(fault2), .freq_count(freq_count2), .retry_cnt(retry_cnt2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // hist[s] is the tick level sampled by the DUT at posedge number s
   always @(negedge clk) begin
      if (tick_per != 0 && cyc % tick_per == 0) pclk_tick = ~pclk_tick;
      if (cyc < HN - 1) hist[cyc + 1] = pclk_tick;
   end

   // A window opening after edge w counts tick toggles sampled at edges w-1 .. w+len-2 (two-flop sync plus edge flop)
   function automatic int win_edges(int w, int len);
      int n = 0;
      for (int s = w - 1; s < w + len - 1; s++) n += (hist[s] != hist[s - 1]) ? 1 : 0;
      return n > SAT ? SAT : n;
   endfunction

   task automatic wait_edge(int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1;
      pll_lock = 0;
      tick_per = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      rst_edge = cyc;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(negedge clk);
      tests++;
      if ({pll_reset, hdmi_reset, ready, fault, freq_count, retry_cnt} !== {4'b1100, 10'd0, 2'd0}) begin
         fails++;
         $display("FAIL reset_state: got %b%b%b%b fc=%0d rc=%0d want 1100 fc=0 rc=0", pll_reset, hdmi_reset, ready, fault, freq_count, retry_cnt);
      end
      tests++;
      if ({pll_reset2, hdmi_reset2, ready2, fault2, freq_count2, retry_cnt2} !== {4'b1100, 10'd0, 2'd0}) begin
         fails++;
         $display("FAIL reset_state2: got %b%b%b%b fc=%0d rc=%0d want 1100 fc=0 rc=0", pll_reset2, hdmi_reset2, ready2, fault2, freq_count2, retry_cnt2);
      end
   endtask

   task automatic test_nominal();
      int d, m, e;
      bit ok;
      for (int it = 0; it < 3; it++) begin
         do_reset();
         tick_per = $urandom_range(6, 7);
         d = $urandom_range(2, 20);
         wait_edge(rst_edge + 3);
         tests++;
         if (pll_reset !== 1'b1) begin fails++; $display("FAIL nom_pllrst_hold: got %b want 1", pll_reset); end
         wait_edge(rst_edge + 4);
         tests++;
         if (pll_reset !== 1'b0) begin fails++; $display("FAIL nom_pllrst_release: got %b want 0", pll_reset); end
         wait_edge(rst_edge + 3 + d);
         pll_lock = 1;
         m = cyc + 1 + 2 + 16;
         wait_edge(m + 63);
         tests++;
         if (ready !== 1'b0) begin fails++; $display("FAIL nom_ready_early: got %b want 0", ready); end
         wait_edge(m + 64);
         e = win_edges(m, 64);
         ok = e >= EMIN && e <= EMAX;
         tests++;
         if ({ready, hdmi_reset, freq_count, retry_cnt} !== {ok, !ok, 10'(e), 2'(ok ? 0 : 1)}) begin
            fails++;
            $display("FAIL nom_result: got rdy=%b hr=%b fc=%0d rc=%0d want rdy=%b hr=%b fc=%0d rc=%0d", ready, hdmi_reset, freq_count, retry_cnt, ok, !ok, e, ok ? 0 : 1);
         end
      end
   endtask

   task automatic test_lock_timeout();
      int hi = 0, pulses = 0, hdmi_lo = 0, first_fault = -1;
      bit prev = 0;
      do_reset();
      for (int k = 0; k <= 320; k++) begin
         wait_edge(rst_edge + k);
         if (pll_reset) hi++;
         if (pll_reset && !prev) pulses++;
         prev = pll_reset;
         if (!hdmi_reset) hdmi_lo++;
         if (fault && first_fault < 0) first_fault = k;
      end
      tests++;
      if (pulses != 3 || hi != 12) begin fails++; $display("FAIL timeout_pulses: got %0d pulses %0d cycles want 3 pulses 12 cycles", pulses, hi); end
      tests++;
      if (hdmi_lo != 0) begin fails++; $display("FAIL timeout_hdmi_held: got %0d low cycles want 0", hdmi_lo); end
      tests++;
      if (first_fault != 312) begin fails++; $display("FAIL timeout_fault_time: got %0d want 312", first_fault); end
      tests++;
      if ({fault, pll_reset, hdmi_reset, ready, retry_cnt} !== {4'b1010, 2'd3}) begin
         fails++;
         $display("FAIL timeout_fault_state: got f=%b pr=%b hr=%b r=%b rc=%0d want 1 0 1 0 rc=3", fault, pll_reset, hdmi_reset, ready, retry_cnt);
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      tests++;
      if ({fault, pll_reset, hdmi_reset, ready, retry_cnt, freq_count} !== {4'b0110, 2'd0, 10'd0}) begin
         fails++;
         $display("FAIL timeout_reset_clear: got f=%b pr=%b hr=%b r=%b rc=%0d fc=%0d want 0 1 1 0 rc=0 fc=0", fault, pll_reset, hdmi_reset, ready, retry_cnt, freq_count);
      end
   endtask

   task automatic test_settle_glitch();
      int j, g, m, e;
      do_reset();
      tick_per = $urandom_range(6, 7);
      wait_edge(rst_edge + 6);
      pll_lock = 1;
      j = cyc + 1;
      wait_edge(j + 9);
      pll_lock = 0;
      g = cyc + 1;
      @(negedge clk);
      pll_lock = 1;
      m = g + 3 + 16;
      wait_edge(g + 4);
      tests++;
      if ({pll_reset, retry_cnt} !== {1'b0, 2'd0}) begin fails++; $display("FAIL glitch_no_retry: got pr=%b rc=%0d want pr=0 rc=0", pll_reset, retry_cnt); end
      wait_edge(m + 63);
      tests++;
      if (ready !== 1'b0) begin fails++; $display("FAIL glitch_full_settle: got rdy=%b want 0", ready); end
      wait_edge(m + 64);
      e = win_edges(m, 64);
      tests++;
      if ({ready, retry_cnt, freq_count} !== {e >= EMIN && e <= EMAX, 2'd0, 10'(e)}) begin
         fails++;
         $display("FAIL glitch_run: got rdy=%b rc=%0d fc=%0d want rdy=1 rc=0 fc=%0d", ready, retry_cnt, freq_count, e);
      end
   endtask

   task automatic test_freq_error();
      int m, e;
      bit ok;
      do_reset();
      tick_per = 4;
      wait_edge(rst_edge + $urandom_range(6, 12));
      pll_lock = 1;
      m = cyc + 1 + 18;
      wait_edge(m + 64);
      e = win_edges(m, 64);
      ok = e >= EMIN && e <= EMAX;
      tests++;
      if ({freq_count, retry_cnt, pll_reset, ready} !== {10'(e), 2'(ok ? 0 : 1), !ok, ok}) begin
         fails++;
         $display("FAIL freq_error: got fc=%0d rc=%0d pr=%b rdy=%b want fc=%0d rc=%0d pr=%b rdy=%b", freq_count, retry_cnt, pll_reset, ready, e, ok ? 0 : 1, !ok, ok);
      end
   endtask

   task automatic test_back_to_back();
      int m, e, c, f;
      bit ok;
      do_reset();
      tick_per = 6;
      wait_edge(rst_edge + 8);
      pll_lock = 1;
      m = cyc + 1 + 18;
      for (int w = 1; w <= 3; w++) begin
         wait_edge(m + 64 * w);
         e = win_edges(m + 64 * (w - 1), 64);
         ok = e >= EMIN && e <= EMAX;
         tests++;
         if ({ready, freq_count} !== {ok, 10'(e)}) begin fails++; $display("FAIL b2b_window%0d: got rdy=%b fc=%0d want rdy=%b fc=%0d", w, ready, freq_count, ok, e); end
      end
      c = cyc + $urandom_range(5, 40);
      wait_edge(c);
      pll_lock = 0;
      wait_edge(c + 2);
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL loss_not_early: got rdy=%b want 1", ready); end
      wait_edge(c + 3);
      tests++;
      if ({ready, hdmi_reset, pll_reset, retry_cnt} !== {3'b011, 2'd1}) begin
         fails++;
         $display("FAIL loss_detect: got rdy=%b hr=%b pr=%b rc=%0d want 0 1 1 rc=1", ready, hdmi_reset, pll_reset, retry_cnt);
      end
      f = c + 3;
      wait_edge(f + 6);
      pll_lock = 1;
      m = cyc + 1 + 18;
      wait_edge(m + 63);
      tests++;
      if (retry_cnt !== 2'd1) begin fails++; $display("FAIL loss_retry_kept: got %0d want 1", retry_cnt); end
      wait_edge(m + 64);
      tests++;
      if ({ready, hdmi_reset, retry_cnt} !== {2'b10, 2'd0}) begin fails++; $display("FAIL loss_recover: got rdy=%b hr=%b rc=%0d want 1 0 rc=0", ready, hdmi_reset, retry_cnt); end
      tick_per = 3;
      wait_edge(m + 128);
      e = win_edges(m + 64, 64);
      ok = e >= EMIN && e <= EMAX;
      tests++;
      if ({ready, freq_count, retry_cnt} !== {ok, 10'(e), 2'(ok ? 0 : 1)}) begin
         fails++;
         $display("FAIL run_out_of_range: got rdy=%b fc=%0d rc=%0d want rdy=%b fc=%0d rc=%0d", ready, freq_count, retry_cnt, ok, e, ok ? 0 : 1);
      end
   endtask

   task automatic test_priority();
      int m, e;
      do_reset();
      tick_per = 6;
      wait_edge(rst_edge + 6);
      pll_lock = 1;
      m = cyc + 1 + 18;
      wait_edge(m + 61);
      pll_lock = 0;
      wait_edge(m + 64);
      e = win_edges(m, 64);
      tests++;
      if ({freq_count, ready, pll_reset, retry_cnt} !== {10'(e), 2'b01, 2'd1}) begin
         fails++;
         $display("FAIL lock_priority: got fc=%0d rdy=%b pr=%b rc=%0d want fc=%0d rdy=0 pr=1 rc=1", freq_count, ready, pll_reset, retry_cnt, e);
      end
   endtask

   task automatic test_saturation();
      int m, e;
      do_reset();
      tick_per = 1;
      wait_edge(rst_edge + 6);
      pll_lock = 1;
      m = cyc + 1 + 18;
      wait_edge(m + 1999);
      tests++;
      if (freq_count2 !== 10'd0) begin fails++; $display("FAIL sat_no_early_latch: got %0d want 0", freq_count2); end
      wait_edge(m + 2000);
      e = win_edges(m, 2000);
      tests++;
      if ({freq_count2, retry_cnt2, pll_reset2, ready2} !== {10'(e), 2'd1, 2'b10}) begin
         fails++;
         $display("FAIL saturation: got fc=%0d rc=%0d pr=%b rdy=%b want fc=%0d rc=1 pr=1 rdy=0", freq_count2, retry_cnt2, pll_reset2, ready2, e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_lock_timeout();
      test_settle_glitch();
      test_freq_error();
      test_back_to_back();
      test_priority();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
